// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the FIR processor run controller.
package proc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int SYNC_STAGES   = 2;

  localparam int LED_STATE_LSB = 5;
  localparam int LED_MODE      = 4;
  localparam int LED_DONE      = 3;
  localparam int LED_SEL_LSB   = 0;

endpackage

// File: rtl/push_debouncer.sv
// Push button synchronizer, debouncer and single-cycle press pulse generator.
module push_debouncer
  import proc_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   push_s;

  assign push_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], push};
      press <= 1'b0;
      // Any cycle agreeing with the accepted level restarts the stability run.
      if (push_s != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= push_s;
          press <= push_s;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/proc_run_ctrl.sv
// Run/sequencing controller: loads filter select under reset, then free-runs
// or single-steps the FIR core, and reports status on the LEDs.
module proc_run_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RESET_HOLD      = 4,
  parameter int SEL_W           = 3,
  parameter int LED_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             ena_switch,
  input  logic [SEL_W-1:0] Switches,
  input  logic             cpu_done,
  output logic             cpu_rst,
  output logic             cpu_en,
  output logic [SEL_W-1:0] filter_sel,
  output logic [LED_W-1:0] LEDs
);

  localparam int HOLD_MAX = (RESET_HOLD > SYNC_STAGES) ? RESET_HOLD : SYNC_STAGES;
  localparam int HC_W     = $clog2(HOLD_MAX + 1);

  logic [SYNC_STAGES-1:0][SEL_W-1:0] sw_sync;
  logic [SYNC_STAGES-1:0]            ena_sync;
  logic [SEL_W-1:0]                  sw_s, sw_pre;
  logic                              mode_step, press, push_level;

  state_t           state, nxt_state;
  logic [HC_W-1:0]  cnt, nxt_cnt;
  logic [SEL_W-1:0] nxt_sel;
  logic [LED_W-1:0] nxt_leds;
  logic             nxt_en;

  assign sw_s      = sw_sync[SYNC_STAGES-1];
  assign sw_pre    = sw_sync[SYNC_STAGES-2];
  assign mode_step = ena_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_sync  <= '0;
      ena_sync <= '0;
    end else begin
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], Switches};
      ena_sync <= {ena_sync[SYNC_STAGES-2:0], ena_switch};
    end
  end

  push_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_push (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .level (push_level),
    .press (press)
  );

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 1'b1;
    nxt_sel   = filter_sel;
    case (state)
      IDLE: if (cnt == HC_W'(SYNC_STAGES - 1)) begin
        // Take the last sync stage's incoming value, so filter_sel matches
        // the synced Switches from the first LOAD cycle onwards.
        nxt_state = LOAD;
        nxt_cnt   = '0;
        nxt_sel   = sw_pre;
      end
      LOAD: if (cnt == HC_W'(RESET_HOLD - 1)) begin
        nxt_state = RUN;
        nxt_cnt   = '0;
      end
      RUN: begin
        nxt_cnt = '0;
        if (sw_s != filter_sel) nxt_state = IDLE;
        else if (cpu_done)      nxt_state = DONE;
      end
      DONE: begin
        nxt_cnt = '0;
        if (sw_s != filter_sel || press) nxt_state = IDLE;
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    nxt_en = (nxt_state == RUN) && (!mode_step || press);
    nxt_leds = '0;
    nxt_leds[LED_STATE_LSB +: 2]   = nxt_state;
    nxt_leds[LED_MODE]             = mode_step;
    nxt_leds[LED_DONE]             = (nxt_state == DONE);
    nxt_leds[LED_SEL_LSB +: SEL_W] = nxt_sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cpu_rst    <= 1'b1;
      cpu_en     <= 1'b0;
      filter_sel <= '0;
      LEDs       <= '0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      cpu_rst    <= (nxt_state == IDLE) || (nxt_state == LOAD);
      cpu_en     <= nxt_en;
      filter_sel <= nxt_sel;
      LEDs       <= nxt_leds;
    end
  end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Directed bench for proc_run_ctrl with hand-computed expectations.
module tb_proc_run_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic       ena_switch;
  logic [2:0] Switches;
  logic       cpu_done;
  logic       cpu_rst;
  logic       cpu_en;
  logic [2:0] filter_sel;
  logic [7:0] LEDs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  proc_run_ctrl #(
    .DEBOUNCE_CYCLES(16),
    .RESET_HOLD     (4),
    .SEL_W          (3),
    .LED_W          (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .ena_switch (ena_switch),
    .Switches   (Switches),
    .cpu_done   (cpu_done),
    .cpu_rst    (cpu_rst),
    .cpu_en     (cpu_en),
    .filter_sel (filter_sel),
    .LEDs       (LEDs)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Assumes reset was just released between edges with Switches=001, free-run.
  task automatic power_on_seq(input string pfx);
    step(1);
    chk({pfx, "_e1_rst"}, cpu_rst, 1'b1);
    chk({pfx, "_e1_led"}, LEDs, 8'h00);
    step(1);
    chk({pfx, "_e2_sel"}, filter_sel, 3'b001);
    chk({pfx, "_e2_led"}, LEDs, 8'h21);
    step(3);
    chk({pfx, "_e5_rst"}, cpu_rst, 1'b1);
    chk({pfx, "_e5_en"}, cpu_en, 1'b0);
    step(1);
    chk({pfx, "_e6_rst"}, cpu_rst, 1'b0);
    chk({pfx, "_e6_en"}, cpu_en, 1'b1);
    chk({pfx, "_e6_led"}, LEDs, 8'h41);
  endtask

  initial begin
    int ones;
    int edges;
    reset = 1'b1; push = 1'b0; ena_switch = 1'b0; Switches = 3'b001; cpu_done = 1'b0;

    #3;
    chk("rst_cpu_rst", cpu_rst, 1'b1);
    chk("rst_cpu_en", cpu_en, 1'b0);
    chk("rst_sel", filter_sel, 3'b000);
    chk("rst_led", LEDs, 8'h00);
    #19 reset = 1'b0;

    // 1: power-on free-run
    power_on_seq("pwr");
    step(2);
    chk("freerun_en", cpu_en, 1'b1);

    // 2: single-step
    ena_switch = 1'b1;
    step(3);
    chk("step_idle_en", cpu_en, 1'b0);
    chk("step_led_mode", LEDs[4], 1'b1);
    push = 1'b1;
    ones = 0;
    for (int i = 1; i <= 45; i++) begin
      step(1);
      if (cpu_en) ones++;
      if (i == 18) chk("step_pre_pulse", cpu_en, 1'b0);
      if (i == 19) chk("step_pulse", cpu_en, 1'b1);
      if (i == 20) begin
        chk("step_post_pulse", cpu_en, 1'b0);
        push = 1'b0;
      end
    end
    chk("step_one_pulse", ones, 1);
    push = 1'b1;
    step(5);
    push = 1'b0;
    ones = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (cpu_en) ones++;
    end
    chk("glitch_no_pulse", ones, 0);
    chk("step_state_run", LEDs[7:5], 3'd2);

    // 3: completion and rerun (free-run)
    ena_switch = 1'b0;
    step(4);
    chk("done_pre_en", cpu_en, 1'b1);
    cpu_done = 1'b1;
    step(1);
    cpu_done = 1'b0;
    chk("done_en_off", cpu_en, 1'b0);
    chk("done_led_state", LEDs[7:5], 3'd3);
    chk("done_led_flag", LEDs[3], 1'b1);
    step(2);
    chk("done_hold", LEDs[7:5], 3'd3);
    push = 1'b1;
    edges = 0;
    while (cpu_rst !== 1'b1 && edges < 40) begin
      step(1);
      edges++;
    end
    chk("rerun_press_lat", edges, 19);
    push = 1'b0;
    chk("rerun_led_idle", LEDs[7:5], 3'd0);
    step(5);
    chk("rerun_e5_rst", cpu_rst, 1'b1);
    step(1);
    chk("rerun_e6_rst", cpu_rst, 1'b0);
    chk("rerun_e6_en", cpu_en, 1'b1);

    // 4: filter change during RUN
    step(25);
    Switches = 3'b100;
    step(2);
    chk("fchg_e2_rst", cpu_rst, 1'b0);
    step(1);
    chk("fchg_e3_rst", cpu_rst, 1'b1);
    chk("fchg_e3_idle", LEDs[7:5], 3'd0);
    step(2);
    chk("fchg_sel", filter_sel, 3'b100);
    chk("fchg_load", LEDs[7:5], 3'd1);
    step(4);
    chk("fchg_run_en", cpu_en, 1'b1);
    chk("fchg_run_led", LEDs, 8'h44);

    // 5: done coincident with synced Switches change
    Switches = 3'b001;
    step(2);
    cpu_done = 1'b1;
    step(1);
    cpu_done = 1'b0;
    chk("simul_idle", LEDs[7:5], 3'd0);
    chk("simul_no_done", LEDs[3], 1'b0);
    chk("simul_rst", cpu_rst, 1'b1);
    step(6);
    chk("simul_resume", LEDs, 8'h41);

    // 6: asynchronous reset mid-run
    step(3);
    chk("mid_pre_en", cpu_en, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst", cpu_rst, 1'b1);
    chk("mid_en", cpu_en, 1'b0);
    chk("mid_sel", filter_sel, 3'b000);
    chk("mid_led", LEDs, 8'h00);
    #3 reset = 1'b0;
    power_on_seq("rep");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
